// File: rtl/hazard_fwd_tracker.sv
// Load-use stall and EX forwarding selects from a shift register of in-flight destination tags.
// Optional stall-cycle counter built only when HAZ_PERF_CNT_EN is defined.
module hazard_fwd_tracker #(
  parameter int REG_AW    = 5,
  parameter int NSRC      = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SELW      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*REG_AW-1:0] id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   flush,
  output logic                   stall,
  output logic [NSRC*SELW-1:0]   fwd_sel_ex,
  output logic [15:0]            stall_count
);

  logic [FWD_DEPTH-1:0] slot_valid;
  logic [FWD_DEPTH-1:0] slot_regwrite;
  logic [FWD_DEPTH-1:0] slot_memread;
  logic [REG_AW-1:0]    slot_rd [FWD_DEPTH];

  logic [NSRC*SELW-1:0] sel_next;
  logic [NSRC-1:0]      op_haz;
  logic                 issue;

  // Scan oldest to youngest so the youngest matching producer overwrites older ones.
  always_comb begin
    sel_next = '0;
    op_haz   = '0;
    for (int k = 0; k < NSRC; k++) begin
      for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
        if (slot_valid[j] && slot_regwrite[j] && (slot_rd[j] != '0) &&
            (slot_rd[j] == id_src[k*REG_AW +: REG_AW]) && id_src_used[k]) begin
          sel_next[k*SELW +: SELW] = SELW'(j + 1);
          op_haz[k]                = slot_memread[j] && (j < LOAD_LAT);
        end
      end
    end
  end

  assign stall = id_valid && !flush && (|op_haz);
  assign issue = id_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid    <= '0;
      slot_regwrite <= '0;
      slot_memread  <= '0;
      for (int j = 0; j < FWD_DEPTH; j++) slot_rd[j] <= '0;
      fwd_sel_ex    <= '0;
    end else begin
      slot_valid[0]    <= issue;
      slot_regwrite[0] <= id_regwrite;
      slot_memread[0]  <= id_memread;
      slot_rd[0]       <= id_rd;
      // A flush kills the wrong-path instruction sitting in slot 0 as it moves on.
      for (int j = 1; j < FWD_DEPTH; j++) begin
        slot_valid[j]    <= slot_valid[j-1] && !(flush && (j == 1));
        slot_regwrite[j] <= slot_regwrite[j-1];
        slot_memread[j]  <= slot_memread[j-1];
        slot_rd[j]       <= slot_rd[j-1];
      end
      fwd_sel_ex <= issue ? sel_next : '0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_count = stall_cnt;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_fwd_tracker.sv
// Bench for hazard_fwd_tracker: two instances (default and LOAD_LAT=2/FWD_DEPTH=3) against an issue-history model.
module tb_hazard_fwd_tracker;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0] id_src_used;
  logic [AW-1:0] id_rd;
  logic id_regwrite, id_memread, flush;

  logic stall_a, stall_b;
  logic [NS*SW-1:0] sel_a, sel_b;
  logic [15:0] cnt_a, cnt_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_fwd_tracker dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall_a), .fwd_sel_ex(sel_a), .stall_count(cnt_a)
  );

  hazard_fwd_tracker #(.FWD_DEPTH(3), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall_b), .fwd_sel_ex(sel_b), .stall_count(cnt_b)
  );

  // Reference: history of what issued each cycle, index 0 = most recent.
  int dep [2] = '{2, 3};
  int lat [2] = '{1, 2};
  bit hv  [2][8];
  bit hrw [2][8];
  bit hmr [2][8];
  logic [AW-1:0] hrd [2][8];
  logic [NS*SW-1:0] msel [2];
  int mcnt [2];

  function automatic void lookup(input int i, input int k, output int sel, output bit haz);
    sel = 0;
    haz = 1'b0;
    if (!id_src_used[k]) return;
    for (int j = 0; j < dep[i]; j++) begin
      if (hv[i][j] && hrw[i][j] && hrd[i][j] != 0 && hrd[i][j] == id_src[k*AW +: AW]) begin
        sel = j + 1;
        haz = hmr[i][j] && (j < lat[i]);
        return;
      end
    end
  endfunction

  function automatic bit mstall(input int i);
    bit h = 1'b0;
    int s;
    bit z;
    for (int k = 0; k < NS; k++) begin
      lookup(i, k, s, z);
      if (z) h = 1'b1;
    end
    return id_valid && !flush && h;
  endfunction

  function automatic int expcnt(input int i);
`ifdef HAZ_PERF_CNT_EN
    return mcnt[i];
`else
    return 0;
`endif
  endfunction

  task automatic step();
    bit st [2];
    logic [NS*SW-1:0] ns [2];
    int s;
    bit z;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      st[i] = mstall(i);
      ns[i] = '0;
      for (int k = 0; k < NS; k++) begin
        lookup(i, k, s, z);
        ns[i][k*SW +: SW] = 3'(s);
      end
      if (rst) begin
        for (int j = 0; j < 8; j++) hv[i][j] = 1'b0;
        msel[i] = '0;
        mcnt[i] = 0;
      end else begin
        for (int j = 7; j > 0; j--) begin
          hv[i][j] = hv[i][j-1]; hrw[i][j] = hrw[i][j-1];
          hmr[i][j] = hmr[i][j-1]; hrd[i][j] = hrd[i][j-1];
        end
        if (flush) hv[i][1] = 1'b0;
        hv[i][0]  = id_valid && !st[i] && !flush;
        hrw[i][0] = id_regwrite;
        hmr[i][0] = id_memread;
        hrd[i][0] = id_rd;
        msel[i] = hv[i][0] ? ns[i] : '0;
        if (st[i] && mcnt[i] < 65535) mcnt[i]++;
      end
    end
    #1;
  endtask

  task automatic instr(input bit v, input int s0, input int s1, input logic [1:0] used,
                       input int rd, input bit rw, input bit mr);
    id_valid = v;
    id_src = {5'(s1), 5'(s0)};
    id_src_used = used;
    id_rd = 5'(rd);
    id_regwrite = rw;
    id_memread = mr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    instr(0, 0, 0, 2'b00, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if (stall_a !== 1'b0 || sel_a !== '0 || cnt_a !== 16'd0 || sel_b !== '0) begin
      miscompares++;
      $display("FAIL reset: stall=%b sel=%h cnt=%0d selb=%h, need 0/0/0/0", stall_a, sel_a, cnt_a, sel_b);
    end
  endtask

  task automatic test_alu_chain();
    do_reset();
    instr(1, 1, 2, 2'b11, 3, 1, 0);
    step();
    instr(1, 3, 4, 2'b11, 6, 1, 0);
    @(negedge clk);
    vectors++;
    if (stall_a !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_stall: got %b need 0", stall_a);
    end
    step();
    vectors++;
    if (sel_a !== 6'b000_001) begin
      miscompares++;
      $display("FAIL alu_sel: got %h need 01", sel_a);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    instr(1, 1, 2, 2'b11, 5, 1, 1);
    step();
    instr(1, 1, 5, 2'b11, 8, 1, 0);
    @(negedge clk);
    vectors++;
    if (stall_a !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_stall1: got %b need 1", stall_a);
    end
    step();
    @(negedge clk);
    vectors++;
    if (stall_a !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_stall2: got %b need 0", stall_a);
    end
    step();
    vectors++;
    if (sel_a !== 6'b010_000) begin
      miscompares++;
      $display("FAIL lu_sel: got %h need 10", sel_a);
    end
    vectors++;
`ifdef HAZ_PERF_CNT_EN
    if (cnt_a !== 16'd1) begin
      miscompares++;
      $display("FAIL lu_count: got %0d need 1", cnt_a);
    end
`else
    if (cnt_a !== 16'd0) begin
      miscompares++;
      $display("FAIL lu_count: got %0d need 0", cnt_a);
    end
`endif
  endtask

  task automatic test_youngest();
    do_reset();
    instr(1, 1, 1, 2'b11, 7, 1, 0);
    step();
    instr(1, 2, 2, 2'b11, 7, 1, 0);
    step();
    instr(1, 7, 1, 2'b01, 9, 1, 0);
    @(negedge clk);
    vectors++;
    if (stall_a !== 1'b0) begin
      miscompares++;
      $display("FAIL young_stall: got %b need 0", stall_a);
    end
    step();
    vectors++;
    if (sel_a !== 6'b000_001) begin
      miscompares++;
      $display("FAIL young_sel: got %h need 01", sel_a);
    end
    do_reset();
    instr(1, 1, 1, 2'b11, 0, 1, 1);
    step();
    instr(1, 0, 0, 2'b11, 9, 1, 0);
    @(negedge clk);
    vectors++;
    if (stall_a !== 1'b0 || stall_b !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_stall: got %b/%b need 0/0", stall_a, stall_b);
    end
    step();
    vectors++;
    if (sel_a !== '0) begin
      miscompares++;
      $display("FAIL r0_sel: got %h need 00", sel_a);
    end
  endtask

  task automatic test_load_lat2();
    int n;
    for (int gap = 0; gap < 2; gap++) begin
      do_reset();
      instr(1, 1, 1, 2'b11, 4, 1, 1);
      step();
      if (gap == 1) begin
        instr(1, 1, 2, 2'b11, 10, 1, 0);
        step();
      end
      instr(1, 4, 1, 2'b01, 11, 1, 0);
      n = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (!stall_b) break;
        n++;
        step();
      end
      vectors++;
      if (n != 2 - gap) begin
        miscompares++;
        $display("FAIL lat2_stalls gap%0d: got %0d need %0d", gap, n, 2 - gap);
      end
      step();
      vectors++;
      if (sel_b !== 6'b000_011) begin
        miscompares++;
        $display("FAIL lat2_sel gap%0d: got %h need 03", gap, sel_b);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    instr(1, 1, 1, 2'b11, 5, 1, 1);
    step();
    instr(1, 1, 5, 2'b10, 8, 1, 0);
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall_a !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_stall: got %b need 0", stall_a);
    end
    step();
    flush = 1'b0;
    vectors++;
    if (sel_a !== '0) begin
      miscompares++;
      $display("FAIL flush_sel: got %h need 00", sel_a);
    end
    @(negedge clk);
    vectors++;
    if (stall_a !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_killed: got %b need 0", stall_a);
    end
    step();
    vectors++;
    if (sel_a !== '0) begin
      miscompares++;
      $display("FAIL flush_killed_sel: got %h need 00", sel_a);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    instr(1, 1, 1, 2'b11, 5, 1, 1);
    step();
    instr(1, 5, 1, 2'b01, 8, 1, 0);
    @(negedge clk);
    vectors++;
    if (stall_a !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got %b need 1", stall_a);
    end
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    vectors++;
    if (stall_a !== 1'b0 || sel_a !== '0 || cnt_a !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid: stall=%b sel=%h cnt=%0d need 0/0/0", stall_a, sel_a, cnt_a);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!(stall_a && $urandom_range(0, 3) != 0)) begin
        instr($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
              2'($urandom_range(0, 3)), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
      flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      vectors++;
      if (stall_a !== mstall(0) || stall_b !== mstall(1)) begin
        miscompares++;
        $display("FAIL rnd_stall c%0d: got %b/%b need %b/%b", c, stall_a, stall_b, mstall(0), mstall(1));
      end
      vectors++;
      if (sel_a !== msel[0] || sel_b !== msel[1]) begin
        miscompares++;
        $display("FAIL rnd_sel c%0d: got %h/%h need %h/%h", c, sel_a, sel_b, msel[0], msel[1]);
      end
      vectors++;
      if (int'(cnt_a) != expcnt(0) || int'(cnt_b) != expcnt(1)) begin
        miscompares++;
        $display("FAIL rnd_cnt c%0d: got %0d/%0d need %0d/%0d", c, cnt_a, cnt_b, expcnt(0), expcnt(1));
      end
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_load_lat2();
    test_flush();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
